// File: rtl/biu_arb_pkg.sv
// Shared definitions for the bus interface unit arbiter: bus command
// encodings, FSM state encoding and the request-size legality check.
package biu_arb_pkg;

    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_LINE = 2'b10;
    localparam logic [1:0] CMD_WR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } biu_state_e;

    // A request size is legal only when exactly one of the four bits is set.
    function automatic logic size_legal(input logic [3:0] size);
        return (size == 4'b0001) || (size == 4'b0010) ||
               (size == 4'b0100) || (size == 4'b1000);
    endfunction

endpackage

// File: rtl/biu_arb_if.sv
// Command/data handshake between the arbiter (master) and the cache bus unit (slave).
interface biu_arb_if #(
    parameter int AW = 32,
    parameter int DW = 64
) ();

    logic          req;
    logic [1:0]    cmd;
    logic [3:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          done;
    logic          err;

    modport master (
        output req, cmd, size, addr, wdata,
        input  ack, rvalid, rdata, done, err
    );

    modport slave (
        input  req, cmd, size, addr, wdata,
        output ack, rvalid, rdata, done, err
    );

endinterface

// File: rtl/biu_rr_arb.sv
// Round-robin grant over NCH requesters. The search starts one past the
// last granted channel, so a waiting channel sees at most NCH-1 others first.
module biu_rr_arb #(
    parameter int NCH = 2,
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic           gnt_vld,
    output logic [IW-1:0]  gnt_idx
);

    logic [IW-1:0] ptr;

    // Nearest pending channel after ptr wins; the loop runs far-to-near so the
    // last hit is the closest one.
    always_comb begin
        logic [IW-1:0] c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = '0;
        for (int i = NCH; i >= 1; i--) begin
            c = IW'((int'(ptr) + i) % NCH);
            if (req[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = c;
            end
        end
    end

    // Pointer follows the channel that was actually granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv && gnt_vld) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/biu_arb.sv
// N-channel front end to the cache bus unit: arbitrates per-channel requests,
// runs one bus transaction at a time and returns beats/responses to the owner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next pending channel, latch its request
// ST_ISSUE | bus_req high with latched fields until bus_ack
// ST_DATA  | count read beats, wait for bus_done / bus_err
// ST_RESP  | one cycle in which trans_rdy or bus_error pulses to owner
module biu_arb
    import biu_arb_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int LINE_BEATS = 8,
    parameter int TMO        = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_read_req,
    input  logic [NCH-1:0]    ch_read_line_req,
    input  logic [NCH-1:0]    ch_wt_req,
    input  logic [4*NCH-1:0]  ch_size,
    input  logic [AW*NCH-1:0] ch_pa,
    input  logic [DW*NCH-1:0] ch_wt_data,
    output logic [NCH-1:0]    ch_line_write,
    output logic [NCH-1:0]    ch_cache_entry_write,
    output logic [NCH-1:0]    ch_trans_rdy,
    output logic [NCH-1:0]    ch_bus_error,
    output logic [DW-1:0]     line_data,
    output logic [10:0]       addr_count,
    biu_arb_if.master         bus
);

    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BB     = DW / 8;
    localparam int OFF_W  = $clog2(LINE_BEATS * BB);
    localparam int BW     = $clog2(LINE_BEATS + 1);
    localparam int TW     = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] WDOG_LOAD = TW'((TMO > 0) ? TMO - 1 : 0);

    biu_state_e    state;
    logic [IW-1:0] own;
    logic [1:0]    cmd_q;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] wdog;
    logic          err_q;

    logic [NCH-1:0] pending;
    logic           gnt_vld;
    logic [IW-1:0]  gnt_idx;
    logic [NCH-1:0] gnt_oh;
    logic [NCH-1:0] own_oh;

    logic           sel_rd, sel_line, sel_wt;
    logic [3:0]     sel_size;
    logic [AW-1:0]  sel_pa;
    logic [DW-1:0]  sel_wdata;
    logic [1:0]     sel_cmd;
    logic           sel_illegal;

    logic           data_phase;
    logic           beat_ok;
    logic           beat_bad;
    logic           is_line;
    logic [BW-1:0]  beats_now;
    logic           fin;
    logic           fin_err;
    logic           wdog_exp;

    assign pending = ch_read_req | ch_read_line_req | ch_wt_req;

    biu_rr_arb #(.NCH(NCH)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (pending),
        .adv     (state == ST_IDLE),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Select the granted channel's request fields and one-hot owner masks.
    always_comb begin
        sel_rd    = 1'b0;
        sel_line  = 1'b0;
        sel_wt    = 1'b0;
        sel_size  = '0;
        sel_pa    = '0;
        sel_wdata = '0;
        gnt_oh    = '0;
        own_oh    = '0;
        for (int c = 0; c < NCH; c++) begin
            gnt_oh[c] = (gnt_idx == IW'(c));
            own_oh[c] = (own == IW'(c));
            if (gnt_idx == IW'(c)) begin
                sel_rd    = ch_read_req[c];
                sel_line  = ch_read_line_req[c];
                sel_wt    = ch_wt_req[c];
                sel_size  = ch_size[4*c +: 4];
                sel_pa    = ch_pa[AW*c +: AW];
                sel_wdata = ch_wt_data[DW*c +: DW];
            end
        end
        sel_cmd     = sel_wt ? CMD_WR : (sel_line ? CMD_LINE : CMD_RD);
        sel_illegal = (sel_rd & sel_line) | (sel_rd & sel_wt) | (sel_line & sel_wt) |
                      !size_legal(sel_size);
    end

    // Classify this cycle's beat and decide whether the transaction ends.
    // An ack cycle is also a data cycle so ack+done collapses into one step.
    always_comb begin
        data_phase = (state == ST_DATA) || ((state == ST_ISSUE) && bus.ack);
        is_line    = (cmd_q == CMD_LINE);
        beat_ok    = 1'b0;
        beat_bad   = 1'b0;
        if (data_phase && bus.rvalid) begin
            case (cmd_q)
                CMD_LINE: begin
                    if (beat_cnt < BW'(LINE_BEATS)) beat_ok  = 1'b1;
                    else                            beat_bad = 1'b1;
                end
                CMD_RD:   beat_ok  = 1'b1;
                default:  beat_bad = 1'b1;
            endcase
        end
        beats_now = beat_cnt + BW'(beat_ok && is_line);
        fin       = data_phase && (bus.done || bus.err);
        fin_err   = bus.err || err_q || beat_bad ||
                    (is_line && (beats_now < BW'(LINE_BEATS)));
        wdog_exp  = (TMO != 0) && ((state == ST_ISSUE) || (state == ST_DATA)) &&
                    (wdog == '0);
    end

    // Transaction sequencer with registered bus and channel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= ST_IDLE;
            own                  <= '0;
            cmd_q                <= '0;
            beat_cnt             <= '0;
            wdog                 <= '0;
            err_q                <= 1'b0;
            ch_line_write        <= '0;
            ch_cache_entry_write <= '0;
            ch_trans_rdy         <= '0;
            ch_bus_error         <= '0;
            line_data            <= '0;
            addr_count           <= '0;
            bus.req              <= 1'b0;
            bus.cmd              <= '0;
            bus.size             <= '0;
            bus.addr             <= '0;
            bus.wdata            <= '0;
        end else begin
            ch_line_write        <= '0;
            ch_cache_entry_write <= '0;
            ch_trans_rdy         <= '0;
            ch_bus_error         <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        own      <= gnt_idx;
                        cmd_q    <= sel_cmd;
                        beat_cnt <= '0;
                        err_q    <= 1'b0;
                        wdog     <= WDOG_LOAD;
                        if (sel_illegal) begin
                            ch_bus_error <= gnt_oh;
                            state        <= ST_RESP;
                        end else begin
                            bus.req   <= 1'b1;
                            bus.cmd   <= sel_cmd;
                            bus.size  <= sel_size;
                            bus.addr  <= (sel_cmd == CMD_LINE) ?
                                         {sel_pa[AW-1:OFF_W], OFF_W'(0)} : sel_pa;
                            bus.wdata <= sel_wdata;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_DATA: begin
                    if (wdog != '0) wdog <= wdog - TW'(1);
                    if (beat_ok) begin
                        line_data     <= bus.rdata;
                        ch_line_write <= own_oh;
                        addr_count    <= is_line ? 11'(beat_cnt * BB) : 11'd0;
                        if (is_line) begin
                            beat_cnt <= beat_cnt + BW'(1);
                            if (beat_cnt == BW'(LINE_BEATS - 1))
                                ch_cache_entry_write <= own_oh;
                        end
                    end
                    if (beat_bad) err_q <= 1'b1;
                    if (fin) begin
                        bus.req <= 1'b0;
                        state   <= ST_RESP;
                        if (fin_err) ch_bus_error <= own_oh;
                        else         ch_trans_rdy <= own_oh;
                    end else if (wdog_exp) begin
                        bus.req      <= 1'b0;
                        ch_bus_error <= own_oh;
                        state        <= ST_RESP;
                    end else if ((state == ST_ISSUE) && bus.ack) begin
                        bus.req <= 1'b0;
                        state   <= ST_DATA;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biu_arb.sv
// Directed bench for biu_arb: single/line/write transactions, round-robin,
// error paths, watchdog, illegal requests and asynchronous reset.
module tb_biu_arb;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int LB  = 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [NCH-1:0]    ch_read_req      = '0;
    logic [NCH-1:0]    ch_read_line_req = '0;
    logic [NCH-1:0]    ch_wt_req        = '0;
    logic [4*NCH-1:0]  ch_size          = '0;
    logic [AW*NCH-1:0] ch_pa            = '0;
    logic [DW*NCH-1:0] ch_wt_data       = '0;
    logic [NCH-1:0]    ch_line_write;
    logic [NCH-1:0]    ch_cache_entry_write;
    logic [NCH-1:0]    ch_trans_rdy;
    logic [NCH-1:0]    ch_bus_error;
    logic [DW-1:0]     line_data;
    logic [10:0]       addr_count;

    biu_arb_if #(.AW(AW), .DW(DW)) bus_if ();

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    biu_arb #(.NCH(NCH), .AW(AW), .DW(DW), .LINE_BEATS(LB), .TMO(TMO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ch_read_req          (ch_read_req),
        .ch_read_line_req     (ch_read_line_req),
        .ch_wt_req            (ch_wt_req),
        .ch_size              (ch_size),
        .ch_pa                (ch_pa),
        .ch_wt_data           (ch_wt_data),
        .ch_line_write        (ch_line_write),
        .ch_cache_entry_write (ch_cache_entry_write),
        .ch_trans_rdy         (ch_trans_rdy),
        .ch_bus_error         (ch_bus_error),
        .line_data            (line_data),
        .addr_count           (addr_count),
        .bus                  (bus_if)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic rd, input logic ln, input logic wt,
                          input logic [3:0] sz, input logic [AW-1:0] pa, input logic [DW-1:0] wd);
        ch_read_req[c]         = rd;
        ch_read_line_req[c]    = ln;
        ch_wt_req[c]           = wt;
        ch_size[4*c +: 4]      = sz;
        ch_pa[AW*c +: AW]      = pa;
        ch_wt_data[DW*c +: DW] = wd;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (bus_if.req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check_eq(tag, bus_if.req, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_ch;
        logic [1:0] exp_oh;

        bus_if.ack    = 1'b0;
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        bus_if.done   = 1'b0;
        bus_if.err    = 1'b0;

        // reset values
        #12;
        check_eq("rst_req", bus_if.req, 0);
        check_eq("rst_cmd", bus_if.cmd, 0);
        check_eq("rst_trdy", ch_trans_rdy, 0);
        check_eq("rst_ldata", line_data, 0);
        rst = 1'b1;

        // single read on ch0
        set_ch(0, 1, 0, 0, 4'b0100, 32'h1000_0004, '0);
        tick();
        check_eq("rd_req", bus_if.req, 1);
        check_eq("rd_cmd", bus_if.cmd, 2'b01);
        check_eq("rd_addr", bus_if.addr, 32'h1000_0004);
        check_eq("rd_size", bus_if.size, 4'b0100);
        tick();
        check_eq("rd_req_hold", bus_if.req, 1);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check_eq("rd_req_drop", bus_if.req, 0);
        tick();
        check_eq("rd_no_early_rdy", ch_trans_rdy, 0);
        bus_if.rvalid = 1'b1; bus_if.rdata = 64'hDEAD_BEEF; bus_if.done = 1'b1;
        tick();
        bus_if.rvalid = 1'b0; bus_if.done = 1'b0;
        check_eq("rd_lw", ch_line_write, 2'b01);
        check_eq("rd_ldata", line_data, 64'hDEAD_BEEF);
        check_eq("rd_trdy", ch_trans_rdy, 2'b01);
        check_eq("rd_berr", ch_bus_error, 0);
        set_ch(0, 0, 0, 0, 4'b0000, '0, '0);
        tick();
        check_eq("rd_trdy_clr", ch_trans_rdy, 0);

        // line read on ch1
        set_ch(1, 0, 1, 0, 4'b1000, 32'h2000_0038, '0);
        tick();
        check_eq("ln_cmd", bus_if.cmd, 2'b10);
        check_eq("ln_addr", bus_if.addr, 32'h2000_0000);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        for (int b = 0; b < LB; b++) begin
            bus_if.rvalid = 1'b1;
            bus_if.rdata  = 64'hC0DE_0000 + 64'(b);
            bus_if.done   = (b == LB - 1);
            tick();
            check_eq($sformatf("ln_lw%0d", b), ch_line_write, 2'b10);
            check_eq($sformatf("ln_ac%0d", b), addr_count, 11'(b * 8));
            check_eq($sformatf("ln_dat%0d", b), line_data, 64'hC0DE_0000 + 64'(b));
            check_eq($sformatf("ln_cew%0d", b), ch_cache_entry_write, (b == LB - 1) ? 2'b10 : 2'b00);
            check_eq($sformatf("ln_trdy%0d", b), ch_trans_rdy, (b == LB - 1) ? 2'b10 : 2'b00);
        end
        bus_if.rvalid = 1'b0; bus_if.done = 1'b0;
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        tick();
        check_eq("ln_trdy_clr", ch_trans_rdy, 0);

        // bus_err after 3 beats of a line read on ch1
        set_ch(1, 0, 1, 0, 4'b1000, 32'h2000_0100, '0);
        tick();
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_if.rvalid = 1'b1; bus_if.rdata = 64'(b);
            tick();
        end
        bus_if.rvalid = 1'b0; bus_if.err = 1'b1;
        tick();
        bus_if.err = 1'b0;
        check_eq("err3_berr", ch_bus_error, 2'b10);
        check_eq("err3_trdy", ch_trans_rdy, 0);
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // done after 5 of 8 beats on ch0
        set_ch(0, 0, 1, 0, 4'b1000, 32'h3000_0048, '0);
        tick();
        check_eq("short_addr", bus_if.addr, 32'h3000_0040);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus_if.rvalid = 1'b1; bus_if.rdata = 64'(b);
            tick();
        end
        bus_if.rvalid = 1'b0; bus_if.done = 1'b1;
        tick();
        bus_if.done = 1'b0;
        check_eq("short_berr", ch_bus_error, 2'b01);
        check_eq("short_trdy", ch_trans_rdy, 0);
        set_ch(0, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // clean write on ch0 with ack and done together
        set_ch(0, 0, 0, 1, 4'b1000, 32'h0000_0040, 64'h0123_4567_89AB_CDEF);
        tick();
        check_eq("wr_cmd", bus_if.cmd, 2'b11);
        check_eq("wr_wdata", bus_if.wdata, 64'h0123_4567_89AB_CDEF);
        bus_if.ack = 1'b1; bus_if.done = 1'b1;
        tick();
        bus_if.ack = 1'b0; bus_if.done = 1'b0;
        check_eq("wr_trdy", ch_trans_rdy, 2'b01);
        check_eq("wr_berr", ch_bus_error, 0);
        set_ch(0, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // write on ch1 that receives a stray read beat
        set_ch(1, 0, 0, 1, 4'b0001, 32'h0000_0080, 64'h55);
        tick();
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 64'h77;
        tick();
        bus_if.rvalid = 1'b0;
        check_eq("wrv_lw", ch_line_write, 0);
        bus_if.done = 1'b1;
        tick();
        bus_if.done = 1'b0;
        check_eq("wrv_berr", ch_bus_error, 2'b10);
        check_eq("wrv_trdy", ch_trans_rdy, 0);
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // contention from reset: grants alternate 1,0,1,0
        rst = 1'b0;
        set_ch(0, 1, 0, 0, 4'b0001, 32'h0000_00A0, '0);
        set_ch(1, 1, 0, 0, 4'b0001, 32'h0000_00B0, '0);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ch = (k % 2 == 0) ? 1 : 0;
            exp_oh = 2'b01 << exp_ch;
            wait_req($sformatf("rr_req%0d", k));
            check_eq($sformatf("rr_addr%0d", k), bus_if.addr, (exp_ch == 1) ? 32'hB0 : 32'hA0);
            bus_if.ack = 1'b1; bus_if.done = 1'b1;
            tick();
            bus_if.ack = 1'b0; bus_if.done = 1'b0;
            check_eq($sformatf("rr_trdy%0d", k), ch_trans_rdy, exp_oh);
            tick();
        end
        set_ch(0, 0, 0, 0, 4'b0000, '0, '0);
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // watchdog: ack never comes; ch1 granted first, ch0 next
        set_ch(0, 1, 0, 0, 4'b0001, 32'h0000_0050, '0);
        set_ch(1, 1, 0, 0, 4'b0001, 32'h0000_0060, '0);
        wait_req("wd_req");
        check_eq("wd_addr", bus_if.addr, 32'h60);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.req !== 1'b1) break;
            n++;
        end
        check_eq("wd_cycles", 64'(n), 64'd16);
        check_eq("wd_berr", ch_bus_error, 2'b10);
        check_eq("wd_trdy", ch_trans_rdy, 0);
        wait_req("wd_next_req");
        check_eq("wd_next_addr", bus_if.addr, 32'h50);
        bus_if.ack = 1'b1; bus_if.done = 1'b1;
        tick();
        bus_if.ack = 1'b0; bus_if.done = 1'b0;
        check_eq("wd_next_trdy", ch_trans_rdy, 2'b01);
        set_ch(0, 0, 0, 0, 4'b0000, '0, '0);
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // illegal: two request bits on ch0, then non-one-hot size on ch1
        set_ch(0, 1, 0, 1, 4'b0100, 32'h0000_0070, '0);
        tick();
        check_eq("ill2_req", bus_if.req, 0);
        check_eq("ill2_berr", ch_bus_error, 2'b01);
        set_ch(0, 0, 0, 0, 4'b0000, '0, '0);
        tick();
        check_eq("ill2_berr_clr", ch_bus_error, 0);
        set_ch(1, 1, 0, 0, 4'b0011, 32'h0000_0074, '0);
        tick();
        check_eq("illsz_req", bus_if.req, 0);
        check_eq("illsz_berr", ch_bus_error, 2'b10);
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        tick();

        // asynchronous reset in the middle of a line read
        set_ch(1, 0, 1, 0, 4'b1000, 32'h2000_0200, '0);
        tick();
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus_if.rvalid = 1'b1; bus_if.rdata = 64'hABC0 + 64'(b);
            tick();
        end
        check_eq("ar_pre_lw", ch_line_write, 2'b10);
        #3;
        rst = 1'b0;
        #1;
        check_eq("ar_lw", ch_line_write, 0);
        check_eq("ar_ldata", line_data, 0);
        check_eq("ar_acnt", addr_count, 0);
        check_eq("ar_addr", bus_if.addr, 0);
        bus_if.rvalid = 1'b0;
        set_ch(1, 0, 0, 0, 4'b0000, '0, '0);
        #2;
        rst = 1'b1;
        bus_if.done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("ar_noresp%0d", i), {ch_trans_rdy, ch_bus_error}, 0);
        end
        bus_if.done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
